pipeline_ctrl_regs: RTL and testbench

PIPELINE_CTRL_REGS -- requirements
Module: pipeline_ctrl_regs

---
 rtl/pipeline_ctrl_regs.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl_regs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_regs.sv
// Pipeline control registers: fetch PC, IF/ID instruction latch, ID/EX..MEM/WB
// control fields, plus saturating stall and taken-branch counters.
module pipeline_ctrl_regs #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush1,
  input  logic        flush2,
  input  logic        flush3,
  input  logic        flush4,
  input  logic        flush5,
  input  logic        branchTakenFlag,
  input  logic [31:0] branchTarget,
  input  logic [31:0] instr_in,
  input  logic [3:0]  Rd_ID,
  input  logic [1:0]  opType_ID,
  input  logic [3:0]  opCode_ID,
  input  logic        regWrite_ID,
  output logic [31:0] pc,
  output logic [31:0] instr_IFID,
  output logic        valid_IFID,
  output logic        valid_IDEX,
  output logic        valid_EXMEM,
  output logic        valid_MEMWB,
  output logic [3:0]  Rd_IDEX,
  output logic [3:0]  Rd_EXMEM,
  output logic [3:0]  Rd_MEMWB,
  output logic [1:0]  opTypeEx,
  output logic [1:0]  opTypeMem,
  output logic [1:0]  opTypeWB,
  output logic [3:0]  opCodeEx,
  output logic [3:0]  opCodeMem,
  output logic [3:0]  opCodeWB,
  output logic        regWriteEx,
  output logic        regWriteMem,
  output logic        regWriteWB,
  output logic [15:0] stall_count,
  output logic [15:0] branch_count
);

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic [1:0] opType;
    logic [3:0] opCode;
    logic       regWrite;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  logic [31:0] pc_q, pc_d;
  logic        fetchValid_q, fetchValid_d;
  logic [31:0] instrIfid_q, instrIfid_d;
  logic        validIfid_q, validIfid_d;
  stage_t      idex_q, idex_d;
  stage_t      exmem_q, exmem_d;
  stage_t      memwb_q, memwb_d;
  logic [15:0] stallCnt_q, stallCnt_d;
  logic [15:0] branchCnt_q, branchCnt_d;

  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (branchTakenFlag) begin
      pc_d = branchTarget;
    end else if (stall) begin
      pc_d = pc_q;
    end

    fetchValid_d = 1'b1;

    // flush2 wins over the stall hold so a stalled, flushed IF/ID becomes a bubble
    instrIfid_d = instr_in;
    validIfid_d = fetchValid_q & ~flush1;
    if (flush2) begin
      instrIfid_d = 32'h0;
      validIfid_d = 1'b0;
    end else if (stall) begin
      instrIfid_d = instrIfid_q;
      validIfid_d = validIfid_q;
    end

    idex_d          = BUBBLE;
    idex_d.valid    = validIfid_q;
    idex_d.rd       = Rd_ID;
    idex_d.opType   = opType_ID;
    idex_d.opCode   = opCode_ID;
    idex_d.regWrite = regWrite_ID & validIfid_q;
    if (stall || flush3) begin
      idex_d = BUBBLE;
    end

    exmem_d = flush4 ? BUBBLE : idex_q;
    memwb_d = flush5 ? BUBBLE : exmem_q;

    stallCnt_d  = (stall && stallCnt_q != 16'hFFFF) ? stallCnt_q + 16'd1 : stallCnt_q;
    branchCnt_d = (branchTakenFlag && branchCnt_q != 16'hFFFF) ? branchCnt_q + 16'd1 : branchCnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      fetchValid_q <= 1'b0;
      instrIfid_q  <= 32'h0;
      validIfid_q  <= 1'b0;
      idex_q       <= BUBBLE;
      exmem_q      <= BUBBLE;
      memwb_q      <= BUBBLE;
      stallCnt_q   <= 16'h0;
      branchCnt_q  <= 16'h0;
    end else begin
      pc_q         <= pc_d;
      fetchValid_q <= fetchValid_d;
      instrIfid_q  <= instrIfid_d;
      validIfid_q  <= validIfid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
      stallCnt_q   <= stallCnt_d;
      branchCnt_q  <= branchCnt_d;
    end
  end

  assign pc           = pc_q;
  assign instr_IFID   = instrIfid_q;
  assign valid_IFID   = validIfid_q;
  assign valid_IDEX   = idex_q.valid;
  assign valid_EXMEM  = exmem_q.valid;
  assign valid_MEMWB  = memwb_q.valid;
  assign Rd_IDEX      = idex_q.rd;
  assign Rd_EXMEM     = exmem_q.rd;
  assign Rd_MEMWB     = memwb_q.rd;
  assign opTypeEx     = idex_q.opType;
  assign opTypeMem    = exmem_q.opType;
  assign opTypeWB     = memwb_q.opType;
  assign opCodeEx     = idex_q.opCode;
  assign opCodeMem    = exmem_q.opCode;
  assign opCodeWB     = memwb_q.opCode;
  assign regWriteEx   = idex_q.regWrite;
  assign regWriteMem  = exmem_q.regWrite;
  assign regWriteWB   = memwb_q.regWrite;
  assign stall_count  = stallCnt_q;
  assign branch_count = branchCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_regs.sv
// Bench for pipeline_ctrl_regs: directed vector table, wrap/saturation sequences,
// and randomized cycles compared against a behavioural pipeline model.
module tb_pipeline_ctrl_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush1, flush2, flush3, flush4, flush5;
  logic        branchTakenFlag;
  logic [31:0] branchTarget, instr_in;
  logic [3:0]  Rd_ID, opCode_ID;
  logic [1:0]  opType_ID;
  logic        regWrite_ID;
  logic [31:0] pc, instr_IFID;
  logic        valid_IFID, valid_IDEX, valid_EXMEM, valid_MEMWB;
  logic [3:0]  Rd_IDEX, Rd_EXMEM, Rd_MEMWB;
  logic [1:0]  opTypeEx, opTypeMem, opTypeWB;
  logic [3:0]  opCodeEx, opCodeMem, opCodeWB;
  logic        regWriteEx, regWriteMem, regWriteWB;
  logic [15:0] stall_count, branch_count;

  pipeline_ctrl_regs dut (
    .clk(clk), .rst(rst), .stall(stall),
    .flush1(flush1), .flush2(flush2), .flush3(flush3), .flush4(flush4), .flush5(flush5),
    .branchTakenFlag(branchTakenFlag), .branchTarget(branchTarget), .instr_in(instr_in),
    .Rd_ID(Rd_ID), .opType_ID(opType_ID), .opCode_ID(opCode_ID), .regWrite_ID(regWrite_ID),
    .pc(pc), .instr_IFID(instr_IFID),
    .valid_IFID(valid_IFID), .valid_IDEX(valid_IDEX), .valid_EXMEM(valid_EXMEM), .valid_MEMWB(valid_MEMWB),
    .Rd_IDEX(Rd_IDEX), .Rd_EXMEM(Rd_EXMEM), .Rd_MEMWB(Rd_MEMWB),
    .opTypeEx(opTypeEx), .opTypeMem(opTypeMem), .opTypeWB(opTypeWB),
    .opCodeEx(opCodeEx), .opCodeMem(opCodeMem), .opCodeWB(opCodeWB),
    .regWriteEx(regWriteEx), .regWriteMem(regWriteMem), .regWriteWB(regWriteWB),
    .stall_count(stall_count), .branch_count(branch_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic [1:0] opType;
    logic [3:0] opCode;
    logic       regWrite;
  } rec_t;

  // Behavioural model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
  logic [31:0] mPc;
  logic        mFetch;
  logic [31:0] mInstr;
  logic        mValidIfid;
  rec_t        mPipe[3];
  int          mStall, mBranch;

  task automatic modelStep();
    rec_t fresh;
    rec_t shifted[3];
    logic [4:0] fl;
    if (rst) begin
      mPc = 32'h0; mFetch = 1'b0; mInstr = 32'h0; mValidIfid = 1'b0;
      for (int s = 0; s < 3; s++) mPipe[s] = '0;
      mStall = 0; mBranch = 0;
      return;
    end
    fl = {flush5, flush4, flush3, flush2, flush1};
    fresh = '{mValidIfid, Rd_ID, opType_ID, opCode_ID, regWrite_ID && mValidIfid};
    if (stall) fresh = '0;
    shifted[0] = fresh;
    shifted[1] = mPipe[0];
    shifted[2] = mPipe[1];
    for (int s = 0; s < 3; s++) mPipe[s] = fl[s + 2] ? rec_t'('0) : shifted[s];
    if (fl[1]) begin
      mInstr = 32'h0; mValidIfid = 1'b0;
    end else if (!stall) begin
      mInstr = instr_in; mValidIfid = mFetch && !fl[0];
    end
    mFetch = 1'b1;
    if (branchTakenFlag) mPc = branchTarget;
    else if (!stall)     mPc = mPc + 32'd4;
    if (stall && mStall < 65535) mStall++;
    if (branchTakenFlag && mBranch < 65535) mBranch++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    rec_t got[3];
    got[0] = '{valid_IDEX, Rd_IDEX, opTypeEx, opCodeEx, regWriteEx};
    got[1] = '{valid_EXMEM, Rd_EXMEM, opTypeMem, opCodeMem, regWriteMem};
    got[2] = '{valid_MEMWB, Rd_MEMWB, opTypeWB, opCodeWB, regWriteWB};
    chk($sformatf("%s pc", tag), pc, mPc);
    chk($sformatf("%s instr_IFID", tag), instr_IFID, mInstr);
    chk($sformatf("%s valid_IFID", tag), {31'b0, valid_IFID}, {31'b0, mValidIfid});
    for (int s = 0; s < 3; s++)
      chk($sformatf("%s stage%0d", tag, s), {20'b0, got[s]}, {20'b0, mPipe[s]});
    chk($sformatf("%s stall_count", tag), {16'b0, stall_count}, mStall);
    chk($sformatf("%s branch_count", tag), {16'b0, branch_count}, mBranch);
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic br,
                               input logic [31:0] tgt, input logic [4:0] fl);
    rst = r; stall = st; branchTakenFlag = br; branchTarget = tgt;
    {flush5, flush4, flush3, flush2, flush1} = fl;
    Rd_ID = 4'h3; opType_ID = 2'h1; opCode_ID = 4'h5; regWrite_ID = 1'b1;
    instr_in = {16'hC0DE, mPc[15:0]};
    @(posedge clk);
    #1;
    modelStep();
  endtask

  // Directed vectors: inputs plus hand-derived pc, {vIFID,vIDEX,vEXMEM,vMEMWB}, counters
  typedef struct packed {
    logic        r, st, br;
    logic [31:0] tgt;
    logic [4:0]  fl;
    logic [31:0] expPc;
    logic [3:0]  expV;
    logic [15:0] expSc, expBc;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic r, logic st, logic br, logic [31:0] tgt, logic [4:0] fl,
                              logic [31:0] p, logic [3:0] v, logic [15:0] sc, logic [15:0] bc);
    vec_t x;
    x = '{r, st, br, tgt, fl, p, v, sc, bc};
    return x;
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branchTakenFlag = 1'b0; branchTarget = 32'h0;
    {flush5, flush4, flush3, flush2, flush1} = 5'b0;
    instr_in = 32'h0; Rd_ID = 4'h0; opType_ID = 2'h0; opCode_ID = 4'h0; regWrite_ID = 1'b0;
    mPc = 32'h0; mFetch = 1'b0; mInstr = 32'h0; mValidIfid = 1'b0;
    for (int s = 0; s < 3; s++) mPipe[s] = '0;
    mStall = 0; mBranch = 0;

    vecs[0]  = mk(1, 0, 0, 32'h0,  5'b00000, 32'h00, 4'b0000, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h04, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h08, 4'b1000, 0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h0C, 4'b1100, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h10, 4'b1110, 0, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h14, 4'b1111, 0, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,  5'b00000, 32'h00, 4'b0000, 0, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h04, 4'b0000, 0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,  5'b00000, 32'h08, 4'b1000, 0, 0);
    vecs[9]  = mk(0, 1, 0, 32'h0,  5'b00000, 32'h08, 4'b1000, 1, 0);
    vecs[10] = mk(0, 1, 0, 32'h0,  5'b00000, 32'h08, 4'b1000, 2, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h0C, 4'b1100, 2, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h10, 4'b1110, 2, 0);
    vecs[13] = mk(0, 0, 1, 32'h40, 5'b01110, 32'h40, 4'b0001, 2, 1);
    vecs[14] = mk(0, 1, 1, 32'h80, 5'b00000, 32'h80, 4'b0000, 3, 2);
    vecs[15] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h84, 4'b1000, 3, 2);
    vecs[16] = mk(0, 0, 0, 32'h0,  5'b00001, 32'h88, 4'b0100, 3, 2);
    vecs[17] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h8C, 4'b1010, 3, 2);
    vecs[18] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h90, 4'b1101, 3, 2);
    vecs[19] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h94, 4'b1110, 3, 2);
    vecs[20] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h98, 4'b1111, 3, 2);
    vecs[21] = mk(1, 1, 1, 32'h40, 5'b00000, 32'h00, 4'b0000, 0, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,  5'b00000, 32'h04, 4'b0000, 0, 0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].r, vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].fl);
      chk($sformatf("vec%0d pc", i), pc, vecs[i].expPc);
      chk($sformatf("vec%0d valids", i),
          {28'b0, valid_IFID, valid_IDEX, valid_EXMEM, valid_MEMWB}, {28'b0, vecs[i].expV});
      chk($sformatf("vec%0d regWriteWB", i), {31'b0, regWriteWB}, {31'b0, vecs[i].expV[0]});
      chk($sformatf("vec%0d stall_count", i), {16'b0, stall_count}, {16'b0, vecs[i].expSc});
      chk($sformatf("vec%0d branch_count", i), {16'b0, branch_count}, {16'b0, vecs[i].expBc});
      if (vecs[i].expV[0])
        chk($sformatf("vec%0d Rd_MEMWB", i), {28'b0, Rd_MEMWB}, 32'h3);
      checkOutput($sformatf("vec%0d", i));
    end

    // PC wraps modulo 2^32
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 5'b00000);
    chk("wrap pc top", pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 32'h0, 5'b00000);
    chk("wrap pc zero", pc, 32'h0);
    checkOutput("wrap");

    // Long stall run saturates stall_count
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 5'b00000);
      if (i == 65533) chk("stall_count pre-sat", {16'b0, stall_count}, 32'h0000_FFFE);
    end
    chk("stall_count saturated", {16'b0, stall_count}, 32'h0000_FFFF);
    chk("pc held through stall", pc, 32'h0);
    checkOutput("sat");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      branchTakenFlag = ($urandom_range(0, 7) == 0);
      branchTarget = {$urandom} & 32'hFFFF_FFFC;
      flush1 = ($urandom_range(0, 9) == 0);
      flush2 = ($urandom_range(0, 9) == 0);
      flush3 = ($urandom_range(0, 9) == 0);
      flush4 = ($urandom_range(0, 9) == 0);
      flush5 = ($urandom_range(0, 9) == 0);
      instr_in = $urandom;
      Rd_ID = 4'($urandom);
      opType_ID = 2'($urandom);
      opCode_ID = 4'($urandom);
      regWrite_ID = 1'($urandom);
      @(posedge clk);
      #1;
      modelStep();
      checkOutput($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
